// File: rtl/jtag_host_driver_if.sv
// jtag_host_driver_if: command/response bundle between a JTAG command source and the driver.
interface jtag_host_driver_if;
   logic        i_cmdValid;
   logic        o_cmdReady;
   logic [1:0]  i_cmdOp;
   logic [3:0]  i_cmdLen;
   logic [15:0] i_cmdData;
   logic        o_rspValid;
   logic [15:0] o_rspData;
   logic        o_busy;
   modport master (
      output i_cmdValid, i_cmdOp, i_cmdLen, i_cmdData,
      input  o_cmdReady, o_rspValid, o_rspData, o_busy
   );
   modport slave (
      input  i_cmdValid, i_cmdOp, i_cmdLen, i_cmdData,
      output o_cmdReady, o_rspValid, o_rspData, o_busy
   );
endinterface

// File: rtl/jtag_host_driver.sv
// jtag_host_driver: turns reset/IR/DR/idle commands into divided-clock TCK/TMS/TDI sequences and captures TDO.
module jtag_host_driver #(
   parameter int CLK_DIV = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   jtag_host_driver_if.slave cmd,
   output logic              o_jtagTCK,
   output logic              o_jtagTMS,
   output logic              o_jtagTDI,
   input  logic              i_jtagTDO
);
   typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
   typedef enum logic [1:0] {PRE, SHIFT, POST} phase_t;
   state_t      state_q, state_d;
   phase_t      ph_q, ph_d, ph_nx;
   logic [7:0]  div_q, div_d;
   logic [3:0]  idx_q, idx_d, idx_nx, len_q, len_d;
   logic [1:0]  op_q, op_d;
   logic [15:0] data_q, data_d, cap_q, cap_d, rsp_q, rsp_d;
   logic        tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d, vld_q, vld_d;
   logic        scan, last, done, half_end;
   // {TMS, TDI} for one TCK cycle; op 11 runs as a SHIFT phase with both pins held low
   function automatic logic [1:0] pins(input logic [1:0] op, input phase_t ph, input logic [3:0] idx,
                                       input logic [3:0] len, input logic [15:0] data);
      logic s;
      s = op[0] ^ op[1];
      return ph == PRE   ? {op == 2'b00 ? idx < 4'd5 : op == 2'b01 ? idx < 4'd2 : idx == 4'd0, 1'b0} :
             ph == SHIFT ? {s && idx == len, s && data[idx]} :
                           {idx == 4'd0, 1'b0};
   endfunction
   always_comb begin
      scan     = op_q[0] ^ op_q[1];
      half_end = div_q == 8'(CLK_DIV - 1);
      last     = ph_q == PRE   ? idx_q == (op_q == 2'b00 ? 4'd5 : op_q == 2'b01 ? 4'd3 : 4'd2) :
                 ph_q == SHIFT ? idx_q == len_q : idx_q == 4'd1;
      done     = last && (ph_q == POST || !scan);
      ph_nx    = !last ? ph_q : ph_q == PRE ? SHIFT : POST;
      idx_nx   = last ? 4'd0 : idx_q + 4'd1;
   end
   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      div_d   = div_q;
      idx_d   = idx_q;
      op_d    = op_q;
      len_d   = len_q;
      data_d  = data_q;
      cap_d   = cap_q;
      rsp_d   = rsp_q;
      tck_d   = tck_q;
      tms_d   = tms_q;
      tdi_d   = tdi_q;
      vld_d   = 1'b0;
      if (state_q == IDLE) begin
         if (cmd.i_cmdValid) begin
            state_d        = LOW;
            op_d           = cmd.i_cmdOp;
            len_d          = cmd.i_cmdLen;
            data_d         = cmd.i_cmdData;
            cap_d          = '0;
            div_d          = '0;
            idx_d          = '0;
            ph_d           = cmd.i_cmdOp == 2'b11 ? SHIFT : PRE;
            {tms_d, tdi_d} = pins(cmd.i_cmdOp, ph_d, 4'd0, cmd.i_cmdLen, cmd.i_cmdData);
         end
      end else if (!half_end) begin
         div_d = div_q + 8'd1;
      end else if (state_q == LOW) begin
         div_d   = '0;
         state_d = HIGH;
         tck_d   = 1'b1;
      end else begin
         div_d = '0;
         tck_d = 1'b0;
         // sampled on the last i_clk of the high half to give the target's synchronizer full margin
         if (ph_q == SHIFT && scan) cap_d[idx_q] = i_jtagTDO;
         if (done) begin
            state_d = IDLE;
            tms_d   = 1'b0;
            tdi_d   = 1'b0;
            vld_d   = 1'b1;
            rsp_d   = cap_q;
         end else begin
            state_d        = LOW;
            ph_d           = ph_nx;
            idx_d          = idx_nx;
            {tms_d, tdi_d} = pins(op_q, ph_nx, idx_nx, len_q, data_q);
         end
      end
   end
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         ph_q    <= PRE;
         div_q   <= '0;
         idx_q   <= '0;
         op_q    <= '0;
         len_q   <= '0;
         data_q  <= '0;
         cap_q   <= '0;
         rsp_q   <= '0;
         tck_q   <= 1'b0;
         tms_q   <= 1'b1;
         tdi_q   <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         div_q   <= div_d;
         idx_q   <= idx_d;
         op_q    <= op_d;
         len_q   <= len_d;
         data_q  <= data_d;
         cap_q   <= cap_d;
         rsp_q   <= rsp_d;
         tck_q   <= tck_d;
         tms_q   <= tms_d;
         tdi_q   <= tdi_d;
         vld_q   <= vld_d;
      end
   end
   assign cmd.o_cmdReady = state_q == IDLE;
   assign cmd.o_busy     = state_q != IDLE;
   assign cmd.o_rspValid = vld_q;
   assign cmd.o_rspData  = rsp_q;
   assign o_jtagTCK      = tck_q;
   assign o_jtagTMS      = tms_q;
   assign o_jtagTDI      = tdi_q;
endmodule

// File: tb/tb_jtag_host_driver.sv
// tb_jtag_host_driver: directed bench for jtag_host_driver with a behavioural TAP target on the pins.
module tb_jtag_host_driver;
   typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUDR, EX2DR, UPDR,
                             SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPIR} tap_t;
   logic clk = 1'b0;
   logic i_rst;
   logic tck, tms, tdi, tdo;
   logic tie1;
   jtag_host_driver_if bus();
   jtag_host_driver #(.CLK_DIV(2)) dut (
      .i_clk(clk), .i_rst(i_rst), .cmd(bus),
      .o_jtagTCK(tck), .o_jtagTMS(tms), .o_jtagTDI(tdi), .i_jtagTDO(tdo)
   );
   always #5 clk = ~clk;
   int n_chk = 0, n_fail = 0, viol = 0, nlog = 0;
   logic tms_log [512];
   logic tdi_log [512];
   tap_t tap = TLR;
   logic [3:0] dr_reg = 4'h5, dr_sh = 4'h0;
   logic tdo_m = 1'b0;
   logic tck_p = 1'b0, tms_p = 1'b0, tdi_p = 1'b0;
   assign tdo = tie1 | tdo_m;
   function automatic tap_t tap_next(input tap_t s, input logic m);
      case (s)
         TLR:     return m ? TLR   : RTI;
         RTI:     return m ? SELDR : RTI;
         SELDR:   return m ? SELIR : CAPDR;
         CAPDR:   return m ? EX1DR : SHDR;
         SHDR:    return m ? EX1DR : SHDR;
         EX1DR:   return m ? UPDR  : PAUDR;
         PAUDR:   return m ? EX2DR : PAUDR;
         EX2DR:   return m ? UPDR  : SHDR;
         UPDR:    return m ? SELDR : RTI;
         SELIR:   return m ? TLR   : CAPIR;
         CAPIR:   return m ? EX1IR : SHIR;
         SHIR:    return m ? EX1IR : SHIR;
         EX1IR:   return m ? UPIR  : PAUIR;
         PAUIR:   return m ? EX2IR : PAUIR;
         EX2IR:   return m ? UPIR  : SHIR;
         default: return m ? SELDR : RTI;
      endcase
   endfunction
   // target TAP: samples on TCK rise, updates TDO on TCK fall, 4-bit DR
   always @(posedge tck) begin
      if (tap == CAPDR) dr_sh <= dr_reg;
      if (tap == SHDR) dr_sh <= {tdi, dr_sh[3:1]};
      if (tap == UPDR) dr_reg <= dr_sh;
      tap <= tap_next(tap, tms);
   end
   always @(negedge tck) tdo_m <= tap == SHDR ? dr_sh[0] : 1'b0;
   always @(posedge tck) begin
      tms_log[nlog] = tms;
      tdi_log[nlog] = tdi;
      nlog = nlog + 1;
   end
   always @(negedge clk) begin
      if (tck_p && tck && (tms != tms_p || tdi != tdi_p)) viol = viol + 1;
      tck_p = tck;
      tms_p = tms;
      tdi_p = tdi;
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask
   function automatic logic [31:0] tms_seq(input int b, input int k);
      logic [31:0] v = '0;
      for (int i = 0; i < k; i++) v = {v[30:0], tms_log[b+i]};
      return v;
   endfunction
   function automatic logic [31:0] tdi_lsb(input int b, input int k);
      logic [31:0] v = '0;
      for (int i = 0; i < k; i++) v[i] = tdi_log[b+i];
      return v;
   endfunction
   task automatic issue(input logic [1:0] op, input logic [3:0] len, input logic [15:0] data, output int b);
      bus.i_cmdOp    = op;
      bus.i_cmdLen   = len;
      bus.i_cmdData  = data;
      bus.i_cmdValid = 1'b1;
      @(posedge clk); #1;
      bus.i_cmdValid = 1'b0;
      b = nlog;
   endtask
   task automatic wait_rsp(input bit poke, input string tag, output int cyc);
      cyc = 1;
      while (!bus.o_rspValid && cyc < 400) begin
         if (poke) begin
            bus.i_cmdValid = cyc >= 10 && cyc < 15;
            bus.i_cmdOp    = 2'b00;
            bus.i_cmdData  = 16'hDEAD;
            if (cyc == 12) chk({tag, "_ready_while_busy"}, 32'(bus.o_cmdReady), 32'd0);
         end
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, "_rsp_seen"}, 32'(bus.o_rspValid), 32'd1);
   endtask
   initial begin
      int b, b2, lat, pulses;
      i_rst = 1'b1;
      tie1 = 1'b0;
      bus.i_cmdValid = 1'b0;
      bus.i_cmdOp = 2'b00;
      bus.i_cmdLen = 4'd0;
      bus.i_cmdData = 16'h0;
      repeat (3) @(posedge clk);
      #1 i_rst = 1'b0;
      chk("rst_tck", 32'(tck), 32'd0);
      chk("rst_tms", 32'(tms), 32'd1);
      chk("rst_tdi", 32'(tdi), 32'd0);
      chk("rst_ready", 32'(bus.o_cmdReady), 32'd1);
      chk("rst_busy", 32'(bus.o_busy), 32'd0);
      chk("rst_rspvalid", 32'(bus.o_rspValid), 32'd0);
      chk("rst_rspdata", 32'(bus.o_rspData), 32'd0);
      @(posedge clk); #1;
      // TAP reset
      issue(2'b00, 4'd7, 16'hFFFF, b);
      chk("t1_busy", 32'(bus.o_busy), 32'd1);
      chk("t1_tck_start", 32'(tck), 32'd0);
      wait_rsp(0, "t1", lat);
      chk("t1_latency", 32'(lat), 32'd25);
      chk("t1_rspdata", 32'(bus.o_rspData), 32'h0);
      chk("t1_tck_rises", 32'(nlog - b), 32'd6);
      chk("t1_tms_seq", tms_seq(b, 6), 32'h3E);
      chk("t1_tap_state", 32'(tap), 32'(RTI));
      chk("t1_ready", 32'(bus.o_cmdReady), 32'd1);
      chk("t1_idle_tms", 32'(tms), 32'd0);
      @(posedge clk); #1;
      chk("t1_rsp_pulse", 32'(bus.o_rspValid), 32'd0);
      // DR scan
      issue(2'b10, 4'd3, 16'h000A, b);
      wait_rsp(0, "t2", lat);
      chk("t2_latency", 32'(lat), 32'd37);
      chk("t2_tms_seq", tms_seq(b, 9), 32'h106);
      chk("t2_tdi_shift", tdi_lsb(b + 3, 4), 32'hA);
      chk("t2_rspdata", 32'(bus.o_rspData), 32'h5);
      chk("t2_dr_updated", 32'(dr_reg), 32'hA);
      chk("t2_tap_state", 32'(tap), 32'(RTI));
      @(posedge clk); #1;
      // IR scan with TDO tied high; a different command is offered while busy
      tie1 = 1'b1;
      issue(2'b01, 4'd15, 16'h1234, b);
      wait_rsp(1, "t3", lat);
      bus.i_cmdValid = 1'b0;
      chk("t3_latency", 32'(lat), 32'd89);
      chk("t3_tck_rises", 32'(nlog - b), 32'd22);
      chk("t3_tdi_shift", tdi_lsb(b + 4, 16), 32'h1234);
      chk("t3_rspdata", 32'(bus.o_rspData), 32'hFFFF);
      chk("t3_tap_state", 32'(tap), 32'(RTI));
      tie1 = 1'b0;
      @(posedge clk); #1;
      chk("t3_rsp_held", 32'(bus.o_rspData), 32'hFFFF);
      // back-to-back: second idle-clock command held valid through the first's response
      issue(2'b11, 4'd1, 16'h0, b);
      bus.i_cmdLen = 4'd2;
      bus.i_cmdValid = 1'b1;
      wait_rsp(0, "t4a", lat);
      chk("t4a_latency", 32'(lat), 32'd9);
      chk("t4a_rspdata", 32'(bus.o_rspData), 32'h0);
      chk("t4a_rises", 32'(nlog - b), 32'd2);
      chk("t4_ready_at_rsp", 32'(bus.o_cmdReady), 32'd1);
      @(posedge clk); #1;
      bus.i_cmdValid = 1'b0;
      b2 = nlog;
      chk("t4b_accepted_busy", 32'(bus.o_busy), 32'd1);
      chk("t4b_tck_low", 32'(tck), 32'd0);
      wait_rsp(0, "t4b", lat);
      chk("t4b_latency", 32'(lat), 32'd13);
      chk("t4b_rises", 32'(nlog - b2), 32'd3);
      chk("t4b_tms_seq", tms_seq(b2, 3), 32'h0);
      chk("t4b_tdi_seq", tdi_lsb(b2, 3), 32'h0);
      chk("t4b_tap_state", 32'(tap), 32'(RTI));
      @(posedge clk); #1;
      // reset during the 4th shift bit of a DR scan
      issue(2'b10, 4'd7, 16'h00FF, b);
      for (int k = 0; k < 100 && nlog < b + 7; k++) begin
         @(posedge clk); #1;
      end
      chk("t5_reached_shift3", 32'(nlog - b), 32'd7);
      chk("t5_tdi_before", 32'(tdi), 32'd1);
      chk("t5_tck_before", 32'(tck), 32'd1);
      i_rst = 1'b1;
      #1;
      chk("t5_tck", 32'(tck), 32'd0);
      chk("t5_tms", 32'(tms), 32'd1);
      chk("t5_tdi", 32'(tdi), 32'd0);
      chk("t5_ready", 32'(bus.o_cmdReady), 32'd1);
      chk("t5_busy", 32'(bus.o_busy), 32'd0);
      pulses = 0;
      @(posedge clk); #1;
      i_rst = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (bus.o_rspValid) pulses++;
         @(posedge clk); #1;
      end
      chk("t5_no_rsp", 32'(pulses), 32'd0);
      chk("t5_rspdata_cleared", 32'(bus.o_rspData), 32'h0);
      issue(2'b00, 4'd0, 16'h0, b);
      wait_rsp(0, "t5r", lat);
      chk("t5_recover_latency", 32'(lat), 32'd25);
      chk("t5_recover_tap", 32'(tap), 32'(RTI));
      chk("tms_tdi_stable_high", 32'(viol), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
